// File: rtl/instr_cache_pkg.sv
// Shared types for the direct-mapped instruction cache.
package instr_cache_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEM_READ = 2'd1,
      UPDATE   = 2'd2
   } state_e;

endpackage

// File: rtl/instr_cache_if.sv
// Fetch-side and memory-side signals of the instruction cache.
interface instr_cache_if #(
   parameter int ADDR_W          = 10,
   parameter int WORDS_PER_BLOCK = 4
);
   localparam int BLK_W = ADDR_W - 2 - $clog2(WORDS_PER_BLOCK);

   logic [31:0]                    PC;
   logic [31:0]                    INSTRUCTION;
   logic                           BUSYWAIT;
   logic                           mem_read;
   logic [BLK_W-1:0]               mem_address;
   logic [32*WORDS_PER_BLOCK-1:0]  mem_readdata;
   logic                           mem_busywait;

   modport slave  (input  PC, mem_readdata, mem_busywait,
                   output INSTRUCTION, BUSYWAIT, mem_read, mem_address);
   modport master (output PC, mem_readdata, mem_busywait,
                   input  INSTRUCTION, BUSYWAIT, mem_read, mem_address);
endinterface

// File: rtl/instr_cache_line_store.sv
// Valid/tag/data arrays: combinational lookup port, synchronous fill port, valid clear.
module instr_cache_line_store #(
   parameter int NUM_SETS        = 8,
   parameter int WORDS_PER_BLOCK = 4,
   parameter int IDX_W           = 3,
   parameter int TAG_W           = 3,
   parameter int OFF_IW          = 2
) (
   input  logic                                   CLK,
   input  logic                                   clr_i,
   input  logic [IDX_W-1:0]                       rd_idx_i,
   input  logic [TAG_W-1:0]                       rd_tag_i,
   input  logic [OFF_IW-1:0]                      rd_off_i,
   output logic                                   hit_o,
   output logic [31:0]                            rd_word_o,
   input  logic                                   fill_i,
   input  logic [IDX_W-1:0]                       fill_idx_i,
   input  logic [TAG_W-1:0]                       fill_tag_i,
   input  logic [WORDS_PER_BLOCK-1:0][31:0]       fill_data_i
);
   logic [NUM_SETS-1:0]                            valid_q;
   logic [NUM_SETS-1:0][TAG_W-1:0]                 tag_q;
   logic [NUM_SETS-1:0][WORDS_PER_BLOCK-1:0][31:0] data_q;

   assign hit_o     = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
   assign rd_word_o = data_q[rd_idx_i][rd_off_i];

   always_ff @(posedge CLK) begin
      if (clr_i)       valid_q             <= '0;
      else if (fill_i) valid_q[fill_idx_i] <= 1'b1;
   end

   // Tag and data are deliberately left uncleared; valid alone gates hits.
   always_ff @(posedge CLK) begin
      if (fill_i) begin
         tag_q[fill_idx_i]  <= fill_tag_i;
         data_q[fill_idx_i] <= fill_data_i;
      end
   end
endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache: same-cycle hits, IDLE/MEM_READ/UPDATE fill FSM,
// saturating hit/miss counters.
module instr_cache
   import instr_cache_pkg::*;
#(
   parameter int ADDR_W          = 10,
   parameter int NUM_SETS        = 8,
   parameter int WORDS_PER_BLOCK = 4,
   parameter int CNT_W           = 16
) (
   input  logic              CLK,
   input  logic              RESET,
   instr_cache_if.slave      bus,
   output logic [CNT_W-1:0]  hit_count,
   output logic [CNT_W-1:0]  miss_count
);
   localparam int OFF_W  = $clog2(WORDS_PER_BLOCK);
   localparam int OFF_IW = (OFF_W > 0) ? OFF_W : 1;
   localparam int IDX_W  = $clog2(NUM_SETS);
   localparam int TAG_W  = ADDR_W - 2 - OFF_W - IDX_W;
   localparam int BLK_W  = TAG_W + IDX_W;

   state_e              state_q;
   logic [BLK_W-1:0]    miss_addr_q;
   logic                first_q;
   logic                mem_read_q;
   logic [CNT_W-1:0]    hit_cnt_q, miss_cnt_q;

   logic [OFF_IW-1:0]   off;
   logic [IDX_W-1:0]    idx;
   logic [TAG_W-1:0]    tag;
   logic                hit, busy, fill;
   logic [31:0]         rd_word;
   logic                unused_pc;

   if (OFF_W > 0) begin : g_off
      assign off = bus.PC[2 +: OFF_W];
   end else begin : g_no_off
      assign off = '0;
   end
   assign idx       = bus.PC[2+OFF_W +: IDX_W];
   assign tag       = bus.PC[2+OFF_W+IDX_W +: TAG_W];
   assign unused_pc = ^{bus.PC[31:ADDR_W], bus.PC[1:0]};

   // mem_busywait is only trusted from the second MEM_READ cycle on.
   assign fill = (state_q == MEM_READ) && !first_q && !bus.mem_busywait && !RESET;
   assign busy = !((state_q == IDLE) && hit);

   assign bus.BUSYWAIT    = busy;
   assign bus.INSTRUCTION = busy ? 32'h0 : rd_word;
   assign bus.mem_read    = mem_read_q;
   assign bus.mem_address = miss_addr_q;
   assign hit_count       = hit_cnt_q;
   assign miss_count      = miss_cnt_q;

   instr_cache_line_store #(
      .NUM_SETS(NUM_SETS), .WORDS_PER_BLOCK(WORDS_PER_BLOCK),
      .IDX_W(IDX_W), .TAG_W(TAG_W), .OFF_IW(OFF_IW)
   ) u_store (
      .CLK        (CLK),
      .clr_i      (RESET),
      .rd_idx_i   (idx),
      .rd_tag_i   (tag),
      .rd_off_i   (off),
      .hit_o      (hit),
      .rd_word_o  (rd_word),
      .fill_i     (fill),
      .fill_idx_i (miss_addr_q[IDX_W-1:0]),
      .fill_tag_i (miss_addr_q[IDX_W +: TAG_W]),
      .fill_data_i(bus.mem_readdata)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= IDLE;
         miss_addr_q <= '0;
         first_q     <= 1'b0;
         mem_read_q  <= 1'b0;
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (hit) begin
                  if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
               end else begin
                  miss_addr_q <= {tag, idx};
                  state_q     <= MEM_READ;
                  mem_read_q  <= 1'b1;
                  first_q     <= 1'b1;
                  if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
               end
            end
            MEM_READ: begin
               if (first_q) begin
                  first_q <= 1'b0;
               end else if (!bus.mem_busywait) begin
                  state_q    <= UPDATE;
                  mem_read_q <= 1'b0;
               end
            end
            UPDATE:  state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_instr_cache.sv
// Directed bench for instr_cache against a 5-cycle-busy instruction memory (word at byte A = A+0x100).
module tb_instr_cache;
   logic       CLK   = 1'b0;
   logic       RESET = 1'b1;
   logic [3:0] hit_count, miss_count;
   int         n_cmp = 0;
   int         n_err = 0;
   logic [2:0] mcnt;

   instr_cache_if #(.ADDR_W(10), .WORDS_PER_BLOCK(4)) bus();

   instr_cache #(
      .ADDR_W(10), .NUM_SETS(8), .WORDS_PER_BLOCK(4), .CNT_W(4)
   ) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .bus       (bus),
      .hit_count (hit_count),
      .miss_count(miss_count)
   );

   always #5 CLK = ~CLK;

   function automatic logic [127:0] blk(input logic [5:0] b);
      logic [127:0] r;
      for (int k = 0; k < 4; k++)
         r[32*k +: 32] = {22'b0, b, 4'b0} + 32'(4*k) + 32'h100;
      return r;
   endfunction

   // Memory raises busywait the cycle after mem_read, holds it 5 cycles, then drops it.
   always @(posedge CLK) begin
      if (RESET || !bus.mem_read) begin
         bus.mem_busywait <= 1'b0;
         mcnt             <= 3'd0;
      end else if (!bus.mem_busywait && mcnt == 3'd0) begin
         bus.mem_busywait <= 1'b1;
         mcnt             <= 3'd5;
         bus.mem_readdata <= blk(bus.mem_address);
      end else if (bus.mem_busywait) begin
         mcnt <= mcnt - 3'd1;
         if (mcnt == 3'd1) bus.mem_busywait <= 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      @(negedge CLK);
      #1;
   endtask

   task automatic wait_ready(input string tag);
      int   n;
      logic leak;
      n    = 0;
      leak = 1'b0;
      while (bus.BUSYWAIT && n < 40) begin
         if (bus.INSTRUCTION != 32'h0) leak = 1'b1;
         step();
         n++;
      end
      chk({tag, "_ready"}, bus.BUSYWAIT, 0);
      chk({tag, "_instr0_busy"}, leak, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      bus.PC = 32'h0;
      RESET  = 1'b1;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RESET = 1'b0;
      #1;
      // reset state
      chk("rst_busy",  bus.BUSYWAIT, 1);
      chk("rst_instr", bus.INSTRUCTION, 0);
      chk("rst_mrd",   bus.mem_read, 0);
      chk("rst_hit",   hit_count, 0);
      chk("rst_miss",  miss_count, 0);

      // 1: cold miss on PC=0
      step();
      chk("t1_mrd",  bus.mem_read, 1);
      chk("t1_addr", bus.mem_address, 6'h00);
      chk("t1_miss", miss_count, 1);
      wait_ready("t1");
      chk("t1_instr", bus.INSTRUCTION, 32'h100);
      chk("t1_hit0",  hit_count, 0);

      // 2: same-block hits
      for (int i = 1; i < 4; i++) begin
         step();
         bus.PC = 32'(4*i);
         #1;
         chk($sformatf("t2_instr%0d", i), bus.INSTRUCTION, 32'h100 + 32'(4*i));
         chk($sformatf("t2_busy%0d", i),  bus.BUSYWAIT, 0);
         chk($sformatf("t2_mrd%0d", i),   bus.mem_read, 0);
      end
      step();
      chk("t2_hits", hit_count, 4);

      // 3: conflict on index 0
      bus.PC = 32'd128;
      #1;
      chk("t3_busy", bus.BUSYWAIT, 1);
      step();
      chk("t3_mrd",  bus.mem_read, 1);
      chk("t3_addr", bus.mem_address, 6'h08);
      wait_ready("t3a");
      chk("t3_instr128", bus.INSTRUCTION, 32'h180);
      bus.PC = 32'd0;
      #1;
      chk("t3_evicted", bus.BUSYWAIT, 1);
      wait_ready("t3b");
      chk("t3_instr0", bus.INSTRUCTION, 32'h100);
      chk("t3_miss",   miss_count, 3);

      // 4: reset in the second MEM_READ cycle
      bus.PC = 32'd32;
      step();
      step();
      chk("t4_mrd_pre", bus.mem_read, 1);
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      #1;
      chk("t4_mrd",  bus.mem_read, 0);
      chk("t4_hit",  hit_count, 0);
      chk("t4_miss", miss_count, 0);
      bus.PC = 32'd0;
      #1;
      chk("t4_busy", bus.BUSYWAIT, 1);
      wait_ready("t4");
      chk("t4_instr", bus.INSTRUCTION, 32'h100);
      chk("t4_miss1", miss_count, 1);

      // 5: PC moves during the fill
      RESET = 1'b1;
      step();
      RESET  = 1'b0;
      bus.PC = 32'd0;
      step();
      chk("t5_addr0", bus.mem_address, 6'h00);
      bus.PC = 32'd16;
      for (int n = 0; n < 40 && bus.mem_read; n++) step();
      chk("t5_fill_done", bus.mem_read, 0);
      chk("t5_upd_busy",  bus.BUSYWAIT, 1);
      step();
      chk("t5_idle_busy", bus.BUSYWAIT, 1);
      chk("t5_idle_mrd",  bus.mem_read, 0);
      step();
      chk("t5_mrd",  bus.mem_read, 1);
      chk("t5_addr", bus.mem_address, 6'h01);
      chk("t5_miss", miss_count, 2);
      wait_ready("t5");
      chk("t5_instr16", bus.INSTRUCTION, 32'h110);
      bus.PC = 32'd0;
      #1;
      chk("t5_blk0_busy", bus.BUSYWAIT, 0);
      chk("t5_blk0", bus.INSTRUCTION, 32'h100);

      // 6: hit counter saturation
      chk("t6_hit0", hit_count, 0);
      for (int i = 0; i < 20; i++) begin
         step();
         if (i == 13) chk("t6_hit14", hit_count, 4'hE);
         bus.PC = 32'(4*(i % 4));
      end
      chk("t6_sat", hit_count, 4'hF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
